// File: rtl/bitmap_scanline_fetch_gen.sv
// Per-scanline VRAM byte-address generator for bitmap BG modes 3/4/5 (valid/ready output).
// Optional horizontal mosaic via `define BITMAP_MOSAIC_EN (adds mosaic_h input).
module bitmap_scanline_fetch_gen #(
    parameter int unsigned       ADDR_W      = 17,
    parameter int unsigned       COORD_W     = 8,
    parameter logic [ADDR_W-1:0] FRAME1_BASE = 'h0A000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic               frame,
    input  logic [COORD_W-1:0] line_y,
`ifdef BITMAP_MOSAIC_EN
    input  logic [3:0]         mosaic_h,
`endif
    output logic [ADDR_W-1:0]  addr,
    output logic [COORD_W-1:0] pix_x,
    output logic               addr_valid,
    input  logic               addr_ready,
    output logic               busy,
    output logic               line_done
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [1:0]          r_mode;
    logic                r_frame;
    logic [COORD_W-1:0]  r_y;
    logic [COORD_W-1:0]  r_x;
    logic [ADDR_W-1:0]   r_addr;
`ifdef BITMAP_MOSAIC_EN
    logic [3:0]          r_mh;
    logic [3:0]          r_mcnt;
    logic [ADDR_W-1:0]   r_lin;
`endif

    logic [COORD_W-1:0]  w_lim_h;
    logic                w_empty;
    logic                w_accept;
    logic                w_hs;
    logic [COORD_W-1:0]  w_last_x;
    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W-1:0]   w_stride;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_row;

    // Empty-line decision uses live inputs since it is taken in the same cycle as start.
    always_comb begin
        w_lim_h = (mode == 2'd2) ? COORD_W'(128) : COORD_W'(160);
        w_empty = (mode == 2'd3) || (line_y >= w_lim_h);
    end

    always_comb begin
        w_last_x = COORD_W'(239);
        w_step   = ADDR_W'(2);
        w_stride = ADDR_W'(480);
        case (r_mode)
            2'd1: begin
                w_step   = ADDR_W'(1);
                w_stride = ADDR_W'(240);
            end
            2'd2: begin
                w_last_x = COORD_W'(159);
                w_stride = ADDR_W'(320);
            end
            default: ;
        endcase
        w_base = (r_frame && (r_mode != 2'd0)) ? FRAME1_BASE : '0;
        w_row  = w_base + ADDR_W'(r_y) * w_stride;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        addr_valid = 1'b0;
        busy       = 1'b0;
        line_done  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept   = 1'b1;
                    w_state_nx = w_empty ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                busy       = 1'b1;
                w_state_nx = S_RUN;
            end
            S_RUN: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                if (addr_ready && (r_x == w_last_x)) w_state_nx = S_DONE;
            end
            S_DONE: begin
                line_done  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (abort) w_state_nx = S_IDLE;
    end

    assign w_hs  = addr_valid && addr_ready;
    assign addr  = r_addr;
    assign pix_x = r_x;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= '0;
            r_frame <= 1'b0;
            r_y     <= '0;
            r_x     <= '0;
            r_addr  <= '0;
`ifdef BITMAP_MOSAIC_EN
            r_mh    <= '0;
            r_mcnt  <= '0;
            r_lin   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_mode  <= mode;
                r_frame <= frame;
                r_y     <= line_y;
`ifdef BITMAP_MOSAIC_EN
                r_mh    <= mosaic_h;
`endif
            end
            if (r_state == S_SETUP) begin
                r_addr <= w_row;
                r_x    <= '0;
`ifdef BITMAP_MOSAIC_EN
                r_lin  <= w_row;
                r_mcnt <= r_mh;
`endif
            end else if (w_hs) begin
                r_x <= r_x + 1'b1;
`ifdef BITMAP_MOSAIC_EN
                // r_lin tracks the true-x address; r_addr only jumps to it at each mosaic block start.
                r_lin <= r_lin + w_step;
                if (r_mcnt == 4'd0) begin
                    r_addr <= r_lin + w_step;
                    r_mcnt <= r_mh;
                end else begin
                    r_mcnt <= r_mcnt - 4'd1;
                end
`else
                r_addr <= r_addr + w_step;
`endif
            end
        end
    end

endmodule
